// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and types for the FND scan path
package fnd_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int BCD_W       = 4;
  localparam int DIGIT_IDX_W = 2;

  // 1 kHz per digit at 100 MHz, 1% of each slot kept dark
  localparam int DEF_SCAN_DIV = 100000;
  localparam int DEF_GUARD    = 1000;

  // packed 4-digit BCD word, index 0 = rightmost digit
  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd4_t;

endpackage

// File: rtl/fnd_scan_prescaler.sv
// rtl/fnd_scan_prescaler.sv - slot prescaler, counts 0..DIV-1 and wraps
//   clk   : system clock
//   reset : synchronous, active-high
//   cnt   : position within the current slot
//   tick  : high in the last cycle of a slot (cnt == DIV-1)
module fnd_scan_prescaler #(
  parameter int DIV = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [$clog2(DIV)-1:0] cnt,
  output logic                   tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - 4-digit FND scan controller with frame-aligned double buffer
//   clk, reset   : system clock, synchronous active-high reset
//   bcd_in/dp_in : value and decimal points to display, captured on load
//   load         : single-cycle capture request
//   digit_sel    : digit index to the anode decoder (0 = rightmost)
//   digit_bcd/dp : nibble and dot of the selected digit
//   digit_blank  : segments must be dark (guard interval or leading zero)
//   frame_tick   : pulse in the last cycle of the digit-3 slot
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int GUARD    = DEF_GUARD,
  parameter int LZ_BLANK = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS*BCD_W-1:0]   bcd_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  output logic [DIGIT_IDX_W-1:0]        digit_sel,
  output logic [BCD_W-1:0]              digit_bcd,
  output logic                          digit_dp,
  output logic                          digit_blank,
  output logic                          frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;
  logic          slot_end;
  logic          frame_end;

  bcd4_t                 pending_bcd;
  logic [NUM_DIGITS-1:0] pending_dp;
  logic                  pending_valid;
  bcd4_t                 shadow_bcd;
  logic [NUM_DIGITS-1:0] shadow_dp;

  logic [NUM_DIGITS-1:0] lz;
  logic                  guard_active;

  fnd_scan_prescaler #(
    .DIV (SCAN_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt),
    .tick  (slot_end)
  );

  assign frame_end  = slot_end && (digit_sel == DIGIT_IDX_W'(NUM_DIGITS - 1));
  assign frame_tick = frame_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_sel <= '0;
    end else if (slot_end) begin
      digit_sel <= digit_sel + 1'b1;
    end
  end

  // Shadow only changes on the frame boundary so a frame never mixes two
  // values; a load landing exactly on the boundary goes straight through.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_bcd   <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      shadow_bcd    <= '0;
      shadow_dp     <= '0;
    end else if (frame_end) begin
      pending_valid <= 1'b0;
      if (load) begin
        shadow_bcd <= bcd_in;
        shadow_dp  <= dp_in;
      end else if (pending_valid) begin
        shadow_bcd <= pending_bcd;
        shadow_dp  <= pending_dp;
      end
    end else if (load) begin
      pending_bcd   <= bcd_in;
      pending_dp    <= dp_in;
      pending_valid <= 1'b1;
    end
  end

  // Digit n is a leading zero when it and every digit left of it are zero.
  always_comb begin
    lz = '0;
    if (LZ_BLANK != 0) begin
      lz[3] = (shadow_bcd[3] == '0);
      lz[2] = lz[3] && (shadow_bcd[2] == '0);
      lz[1] = lz[2] && (shadow_bcd[1] == '0);
    end
  end

  generate
    if (GUARD > 0) begin : g_guard
      assign guard_active = (int'(cnt) < GUARD);
    end else begin : g_no_guard
      assign guard_active = 1'b0;
    end
  endgenerate

  assign digit_bcd   = shadow_bcd[digit_sel];
  assign digit_dp    = shadow_dp[digit_sel] && !lz[digit_sel];
  assign digit_blank = guard_active || lz[digit_sel];

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit FND in the stopwatch display path.
- Sits directly upstream of the 2-to-4 anode decoder and feeds it the 2-bit digit index.
- Also presents that digit's BCD nibble and dot bit to the segment encoder.
- Double-buffers the displayed value so updates land only on frame boundaries (no tearing).
- Provides leading-zero blanking and a per-slot anti-ghosting guard interval.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 2
GUARD, 1000, cycles at the start of each slot during which the digit is forced dark; must be < SCAN_DIV
LZ_BLANK, 1, 1 = blank leading zeros on digits 3..1; 0 = show all digits

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
bcd_in  input  16  packed BCD; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
dp_in  input  4  decimal-point enables, bit n = digit n
load  input  1  single-cycle request to capture bcd_in/dp_in for display
digit_sel  output  2  current digit index, drives the anode decoder (0 -> rightmost)
digit_bcd  output  4  BCD nibble of the selected digit (shadow register)
digit_dp  output  1  dot bit of the selected digit
digit_blank  output  1  1 = segments must be dark this cycle
frame_tick  output  1  one-cycle pulse in the last cycle of digit-3 slot

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high; sampled only on the rising edge of clk.
- Prescaler cnt:
  - Width $clog2(SCAN_DIV); counts 0..SCAN_DIV-1, then wraps to 0.
  - slot_end = (cnt == SCAN_DIV-1).
- Digit index: digit_sel increments by 1 mod 4 on slot_end (3 -> 0 wrap).
- frame_end = slot_end && digit_sel == 3; frame_tick = frame_end.
- Registers:
  - pending_bcd[15:0], pending_dp[3:0], pending_valid.
  - shadow_bcd[15:0], shadow_dp[3:0].
- Update rules, at each clk edge:
  - load && !frame_end: pending <= inputs, pending_valid <= 1.
  - frame_end && load: shadow <= bcd_in/dp_in directly (bypass), pending_valid <= 0.
  - frame_end && !load && pending_valid: shadow <= pending, pending_valid <= 0.
  - frame_end && !load && !pending_valid: shadow holds.
  - Multiple loads within one frame: last one wins.
- Output selection:
  - digit_bcd = shadow_bcd[4*digit_sel +: 4] and digit_dp = shadow_dp[digit_sel].
  - Both are combinational from registers, so they change in the same cycle as digit_sel (zero latency).
- Leading-zero blanking (LZ_BLANK=1):
  - Digit n (n = 3..1) is blanked when shadow nibbles n..3 are all 4'h0.
  - Digit 0 is never LZ-blanked.
  - Nibbles 10..15 are non-zero and pass through unchanged.
  - A blanked digit also suppresses its dp.
- digit_blank = (cnt < GUARD) || lz_blank(digit_sel). With GUARD=0, only the LZ term applies.
- Reset values:
  - cnt=0, digit_sel=0, shadow=0, pending=0, pending_valid=0.
  - Outputs: digit_bcd=0, digit_dp=0, frame_tick=0, digit_blank=1 (for GUARD>0).
- Reset mid-frame: scan restarts at digit 0 with cnt=0; any pending load is discarded.
- No back-pressure. load is honoured every cycle.

Decomposition:
- Package fnd_pkg:
  - NUM_DIGITS=4, BCD_W=4, DIGIT_IDX_W=2.
  - Default SCAN_DIV/GUARD constants.
  - A typedef for the packed 4-digit BCD word.
- One sub-module, fnd_scan_prescaler: parameter DIV, ports clk, reset, cnt, tick (tick = cnt==DIV-1).
- Buffering, blanking and muxing stay in fnd_scan_ctrl.

Test Plan:
Run the bench with SCAN_DIV=8, GUARD=2, LZ_BLANK=1.
- Free-run after reset -> digit_sel stays 0 for 8 cycles, then steps 1,2,3,0; frame_tick is high exactly 1 cycle per 32 (digit_sel=3, cnt=7).
- load bcd_in=16'h1234 while digit_sel=1 -> digit_bcd stays 0 until the frame wraps; then slots 0,1,2,3 show 4,3,2,1.
- load 16'h0040 -> digits 3,2 have digit_blank=1 all slot; digit1=4 and digit0=0 are blanked only at cnt 0,1. Then load 16'h0000 -> only digit 0 is shown.
- load asserted in the frame_end cycle with 16'h5678 -> shadow = 5678 from the next cycle; an earlier pending 16'h1111 in that frame is never displayed.
- Guard check -> digit_blank=1 at cnt 0,1 of every slot regardless of value. dp_in=4'b0100 with 16'h9999 -> digit_dp=1 only in slot 2, and 0 during LZ blank.
- Assert reset at digit_sel=2 with pending_valid=1 -> next cycle digit_sel=0, digit_bcd=0, pending discarded (still 0 after next frame_end).
